// File: rtl/mips_pipe_pkg.sv
// Shared control-field bit indices, FSM state type and forwarding encodings
// for the 5-stage MIPS32 pipeline controller.
package mips_pipe_pkg;

    // M control field bit positions
    localparam int unsigned MEM_READ   = 0;
    localparam int unsigned MEM_WRITE  = 1;
    localparam int unsigned BRANCH     = 2;

    // WB control field bit positions
    localparam int unsigned REG_WRITE  = 0;
    localparam int unsigned MEM_TO_REG = 1;

    // Sequencing FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

    // EX operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection and EX forwarding selection.
// HAZ_FORWARD_EN: when defined, forwarding is active and only load-use stalls;
// otherwise forwarding is off and any RegWrite match in EX or MEM stalls.
module hazard_fwd_unit #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned S_WB      = 2,
    parameter int unsigned S_M       = 3
) (
    input  logic [ADDR_SIZE-1:0] id_rs,
    input  logic [ADDR_SIZE-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [ADDR_SIZE-1:0] ex_rs,
    input  logic [ADDR_SIZE-1:0] ex_rt,
    input  logic [ADDR_SIZE-1:0] ex_rd,
    input  logic [S_M-1:0]       ex_M,
    input  logic [S_WB-1:0]      ex_WB,
    input  logic [S_WB-1:0]      mem_WB,
    input  logic [ADDR_SIZE-1:0] mem_rd,
    input  logic [S_WB-1:0]      wb_WB,
    input  logic [ADDR_SIZE-1:0] wb_rd,
    output logic                 haz_stall_c,
    output logic [1:0]           fwd_a_c,
    output logic [1:0]           fwd_b_c
);
    import mips_pipe_pkg::*;

    // $0 is hardwired zero, so it never forms a dependency
    function automatic logic raw_match(input logic [ADDR_SIZE-1:0] src,
                                       input logic [ADDR_SIZE-1:0] dst);
        return (dst != '0) && (dst == src);
    endfunction

    logic ex_dep;
    assign ex_dep = raw_match(id_rs, ex_rd) || (id_uses_rt && raw_match(id_rt, ex_rd));

    // Bits only some build variants consume
    logic unused_ok;
    assign unused_ok = ^{ex_M, mem_WB, wb_WB, ex_rs, ex_rt, wb_rd, mem_rd};

`ifdef HAZ_FORWARD_EN
    // EX/MEM result is younger than MEM/WB, so it wins
    function automatic logic [1:0] fwd_sel(input logic [ADDR_SIZE-1:0] src);
        if (mem_WB[REG_WRITE] && raw_match(src, mem_rd)) return FWD_MEM;
        if (wb_WB[REG_WRITE] && raw_match(src, wb_rd))   return FWD_WB;
        return FWD_RF;
    endfunction

    assign haz_stall_c = ex_M[MEM_READ] && ex_WB[REG_WRITE] && ex_dep;
    assign fwd_a_c     = fwd_sel(ex_rs);
    assign fwd_b_c     = fwd_sel(ex_rt);
`else
    logic mem_dep;
    assign mem_dep = raw_match(id_rs, mem_rd) || (id_uses_rt && raw_match(id_rt, mem_rd));

    // WB writes the register file in the first half-cycle, so it never stalls
    assign haz_stall_c = (ex_WB[REG_WRITE] && ex_dep) || (mem_WB[REG_WRITE] && mem_dep);
    assign fwd_a_c     = FWD_RF;
    assign fwd_b_c     = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencing controller: register enables/flushes, branch redirect,
// data hazard stalls and the data-memory wait/timeout FSM.
// Optional feature macro: HAZ_FORWARD_EN (EX operand forwarding).
module pipe_ctrl_unit #(
    parameter int unsigned ADDR_SIZE   = 5,
    parameter int unsigned S_WB        = 2,
    parameter int unsigned S_M         = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] id_rs,
    input  logic [ADDR_SIZE-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic [ADDR_SIZE-1:0] ex_rs,
    input  logic [ADDR_SIZE-1:0] ex_rt,
    input  logic [ADDR_SIZE-1:0] ex_rd,
    input  logic [S_M-1:0]       ex_M,
    input  logic [S_WB-1:0]      ex_WB,
    input  logic [S_M-1:0]       mem_M,
    input  logic [S_WB-1:0]      mem_WB,
    input  logic [ADDR_SIZE-1:0] mem_rd,
    input  logic                 mem_zero,
    input  logic [S_WB-1:0]      wb_WB,
    input  logic [ADDR_SIZE-1:0] wb_rd,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 pc_src,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 mem_err,
    output logic [15:0]          stall_cnt
);
    import mips_pipe_pkg::*;

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    ctrl_state_e      state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_cnt;
    logic             mem_access, branch_taken, frozen;
    logic             haz_stall_c;
    logic [1:0]       fwd_a_c, fwd_b_c;

    assign mem_access   = mem_M[MEM_READ] | mem_M[MEM_WRITE];
    assign branch_taken = mem_M[BRANCH] & mem_zero;

    hazard_fwd_unit #(
        .ADDR_SIZE (ADDR_SIZE),
        .S_WB      (S_WB),
        .S_M       (S_M)
    ) u_haz (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_M        (ex_M),
        .ex_WB       (ex_WB),
        .mem_WB      (mem_WB),
        .mem_rd      (mem_rd),
        .wb_WB       (wb_WB),
        .wb_rd       (wb_rd),
        .haz_stall_c (haz_stall_c),
        .fwd_a_c     (fwd_a_c),
        .fwd_b_c     (fwd_b_c)
    );

    // FSM state and memory wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    // Next state and prioritised pipeline controls: ERROR > freeze > branch > hazard
    always_comb begin
        next_state  = state;
        next_cnt    = wait_cnt;
        frozen      = 1'b0;
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_src      = 1'b0;
        fwd_a       = fwd_a_c;
        fwd_b       = fwd_b_c;

        unique case (state)
            RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ready) begin
                    frozen   = 1'b1;
                    next_cnt = CNT_W'(1);
                    next_state = (next_cnt >= CNT_W'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                dmem_req = mem_access;
                if (dmem_ready) begin
                    next_state = RUN;
                end else begin
                    frozen   = 1'b1;
                    next_cnt = wait_cnt + CNT_W'(1);
                    if (next_cnt >= CNT_W'(MEM_TIMEOUT)) next_state = ERROR;
                end
            end
            ERROR: begin
                frozen = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase

        if (frozen) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (branch_taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == RUN && haz_stall_c) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        if (rst) begin
            dmem_req    = 1'b0;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pc_src      = 1'b0;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end
    end

    // Sticky error: only reset leaves ERROR
    assign mem_err = (state == ERROR);

    // Saturating count of PC-hold cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
// Honours HAZ_FORWARD_EN the same way as the design.
module tb_pipe_ctrl_unit;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, mem_zero, dmem_ready;
    logic [2:0] ex_M, mem_M;
    logic [1:0] ex_WB, mem_WB, wb_WB;
    logic       dmem_req, pc_en, ifid_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, pc_src, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: whether the memory access is mid-wait, how many
    // not-ready cycles it has seen, error latch, and the stall tally.
    bit m_err, m_waiting;
    int m_waited, m_stalls;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.ADDR_SIZE(5), .S_WB(2), .S_M(3), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_M(ex_M), .ex_WB(ex_WB),
        .mem_M(mem_M), .mem_WB(mem_WB), .mem_rd(mem_rd), .mem_zero(mem_zero),
        .wb_WB(wb_WB), .wb_rd(wb_rd), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic bit reads(input logic [4:0] dst);
        return dep(id_rs, dst) || (id_uses_rt && dep(id_rt, dst));
    endfunction

    function automatic bit data_hazard();
`ifdef HAZ_FORWARD_EN
        return ex_M[0] && ex_WB[0] && reads(ex_rd);
`else
        return (ex_WB[0] && reads(ex_rd)) || (mem_WB[0] && reads(mem_rd));
`endif
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] src);
`ifdef HAZ_FORWARD_EN
        if (mem_WB[0] && dep(src, mem_rd)) return 2'b10;
        if (wb_WB[0] && dep(src, wb_rd))   return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_M = 3'b000; ex_WB = 2'b00;
        mem_M = 3'b000; mem_WB = 2'b00; mem_rd = 5'd0; mem_zero = 1'b0;
        wb_WB = 2'b00; wb_rd = 5'd0; dmem_ready = 1'b1;
    endtask

    // Compare all outputs against the model mid-cycle, then clock and advance the model
    task automatic tick();
        logic       frozen, acc;
        logic [3:0] e_en;
        logic [2:0] e_fl;
        logic       e_src, e_req, e_err;
        logic [1:0] e_fa, e_fb;
        @(negedge clk);
        acc = mem_M[0] | mem_M[1];
        frozen = 1'b0;
        e_en = 4'hF; e_fl = 3'b000; e_src = 1'b0; e_req = 1'b0; e_err = 1'b0;
        e_fa = 2'b00; e_fb = 2'b00;
        if (rst) begin
            e_en = 4'h0;
        end else if (m_err) begin
            e_en = 4'h0;
            e_err = 1'b1;
            frozen = 1'b1;
        end else begin
            e_req  = acc;
            frozen = (m_waiting || acc) && !dmem_ready;
            if (frozen) e_en = 4'h0;
            else if (mem_M[2] && mem_zero) begin e_src = 1'b1; e_fl = 3'b111; end
            else if (!m_waiting && data_hazard()) begin e_en = 4'b0011; e_fl = 3'b010; end
        end
        if (!rst) begin
            e_fa = fwd_of(ex_rs);
            e_fb = fwd_of(ex_rt);
        end
        check("enables", 16'({pc_en, ifid_en, exmem_en, memwb_en}), 16'(e_en));
        check("flushes", 16'({ifid_flush, idex_flush, exmem_flush}), 16'(e_fl));
        check("pc_src", 16'(pc_src), 16'(e_src));
        check("dmem_req", 16'(dmem_req), 16'(e_req));
        check("mem_err", 16'(mem_err), 16'(e_err));
        check("fwd", 16'({fwd_a, fwd_b}), 16'({e_fa, e_fb}));
        check("stall_cnt", stall_cnt, rst ? 16'd0 : 16'(m_stalls));
        @(posedge clk);
        if (rst) begin
            m_err = 0; m_waiting = 0; m_waited = 0; m_stalls = 0;
        end else begin
            if (!e_en[3] && m_stalls < 65535) m_stalls++;
            if (!m_err) begin
                if (frozen) begin
                    m_waited++;
                    m_waiting = 1;
                    if (m_waited >= T) begin m_err = 1; m_waiting = 0; end
                end else begin
                    m_waiting = 0;
                    m_waited = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        m_err = 0; m_waiting = 0; m_waited = 0; m_stalls = 0;
        idle();
        rst = 1'b1;
        // Reset with a pending-looking access: nothing may be requested
        mem_M = 3'b001; dmem_ready = 1'b0;
        tick(); tick();
        idle();
        rst = 1'b0;
        tick();

        // Load-use: lw $2 in EX, ID reads rs=2 -> one bubble
        ex_M = 3'b001; ex_WB = 2'b11; ex_rd = 5'd2; id_rs = 5'd2;
        tick();
        check("lu_stall_cnt", stall_cnt, 16'd1);
        idle(); mem_M = 3'b001; mem_WB = 2'b11; mem_rd = 5'd2;
        tick();
        idle(); tick();

        // Load with 3 wait cycles
        mem_M = 3'b001; dmem_ready = 1'b0;
        tick(); tick(); tick();
        check("wait_dmem_req", 16'(dmem_req), 16'd1);
        dmem_ready = 1'b1;
        tick();
        idle(); tick();

        // Taken branch beats a simultaneous load-use match
        mem_M = 3'b100; mem_zero = 1'b1;
        ex_M = 3'b001; ex_WB = 2'b11; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        tick();
        idle(); tick();

`ifdef HAZ_FORWARD_EN
        // EX/MEM beats MEM/WB; $0 never forwards
        mem_WB = 2'b01; mem_rd = 5'd5; wb_WB = 2'b01; wb_rd = 5'd5; ex_rs = 5'd5; ex_rt = 5'd0;
        tick();
        check("fwd_a_mem", 16'(fwd_a), 16'd2);
        check("fwd_b_zero", 16'(fwd_b), 16'd0);
        mem_WB = 2'b00; ex_rt = 5'd5;
        tick();
        idle(); tick();
`else
        // add $3 in EX, then in MEM: two stall cycles
        ex_WB = 2'b01; ex_rd = 5'd3; id_rs = 5'd3;
        tick();
        ex_WB = 2'b00; ex_rd = 5'd0; mem_WB = 2'b01; mem_rd = 5'd3;
        tick();
        check("raw_stall_cnt", stall_cnt, 16'(m_stalls));
        idle(); tick();
`endif

        // Randomized traffic; inputs other than dmem_ready hold while frozen
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            if (!m_waiting) begin
                id_rs = 5'($urandom_range(3)); id_rt = 5'($urandom_range(3));
                id_uses_rt = 1'($urandom);
                ex_rs = 5'($urandom_range(3)); ex_rt = 5'($urandom_range(3));
                ex_rd = 5'($urandom_range(3));
                ex_M = 3'($urandom); ex_WB = 2'($urandom);
                mem_M = 3'($urandom); mem_WB = 2'($urandom);
                mem_rd = 5'($urandom_range(3)); mem_zero = 1'($urandom);
                wb_WB = 2'($urandom); wb_rd = 5'($urandom_range(3));
            end
            dmem_ready = ($urandom_range(9) < 7);
            tick();
        end

        // Reset during a wait aborts it; no request afterwards
        idle(); rst = 1'b1; tick();
        rst = 1'b0; tick();
        mem_M = 3'b001; dmem_ready = 1'b0;
        tick(); tick();
        rst = 1'b1; tick();
        idle(); rst = 1'b0; tick();
        check("no_req_after_rst", 16'(dmem_req), 16'd0);

        // Timeout: MEM_TIMEOUT not-ready cycles -> ERROR
        mem_M = 3'b010; dmem_ready = 1'b0;
        for (int i = 0; i < T; i++) tick();
        check("timeout_err", 16'(mem_err), 16'd1);
        check("timeout_req", 16'(dmem_req), 16'd0);
        dmem_ready = 1'b1;
        tick(); tick();
        rst = 1'b1; tick();
        check("rst_clears_err", 16'(mem_err), 16'd0);
        rst = 1'b0; idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipeline sequencing controller for the 5-stage MIPS32 core. It drives enable/flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and RAW hazards, resolves taken branches at the MEM stage, and handshakes the data memory with a wait/timeout FSM. It sits beside the datapath and consumes the control fields that the ID/EX, EX/MEM and MEM/WB registers already carry.

## Interface
- ADDR_SIZE, 5, register-address width
- S_WB, 2, WB control width; bit0 RegWrite, bit1 MemToReg
- S_M, 3, M control width; bit0 MemRead, bit1 MemWrite, bit2 Branch
- MEM_TIMEOUT, 15, maximum dmem wait cycles before error (≥1)
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  ADDR_SIZE  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rs, ex_rt, ex_rd  in  ADDR_SIZE  ID/EX register fields (ex_rd = selected write address)
- ex_M  in  S_M; ex_WB  in  S_WB  ID/EX control
- mem_M  in  S_M; mem_WB  in  S_WB; mem_rd  in  ADDR_SIZE; mem_zero  in  1  EX/MEM outputs
- wb_WB  in  S_WB; wb_rd  in  ADDR_SIZE  MEM/WB outputs
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory access request
- pc_en, ifid_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous bubble insert (control fields zeroed)
- pc_src  out  1  select branch target
- fwd_a, fwd_b  out  2  EX operand forwarding select
- mem_err  out  1  sticky memory-timeout error
- stall_cnt  out  16  saturating count of cycles with pc_en=0

## Operation
- FSM states RUN, MEM_WAIT, ERROR; reset state RUN.
- mem_access = mem_M[0] | mem_M[1]. dmem_req = mem_access while in RUN or MEM_WAIT.
- RUN with mem_access and !dmem_ready: freeze the pipeline (all *_en=0, no flushes), load the wait counter with 1, and go to MEM_WAIT.
- MEM_WAIT: keep the pipeline frozen and increment the counter each cycle.
  - On dmem_ready, all enables =1 that cycle and the FSM returns to RUN.
  - If the counter reaches MEM_TIMEOUT without ready, go to ERROR.
- ERROR: all enables 0, dmem_req 0, mem_err=1. Only rst exits.
- Branch taken = mem_M[2] & mem_zero, evaluated only when the pipe is not frozen. Response: pc_src=1, and ifid_flush, idex_flush, exmem_flush =1 for that one cycle.
- Load-use hazard in RUN, not frozen, no taken branch. Condition: ex_M[0] & ex_WB[0] & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). Response: pc_en=0, ifid_en=0, idex_flush=1; exmem/memwb advance.
- Priority: ERROR > memory freeze > taken branch > data hazard.
- Register $0 never causes a hazard or a forward.
- stall_cnt increments on every cycle with pc_en=0, saturates at 0xFFFF, and clears only on rst.

## Timing
- While rst is high: state=RUN, all *_en=0, all *_flush=0, pc_src=0, dmem_req=0, fwd_a=fwd_b=00, mem_err=0, stall_cnt=0.
- Outputs are combinational from the registered state plus the current inputs. The FSM, wait counter, mem_err and stall_cnt update on posedge clk.
- Zero-wait access (dmem_ready with dmem_req): no stall.
- N-wait access: exactly N freeze cycles.
- Load-use bubble lasts 1 cycle. Branch penalty is 3 flushed slots.
- A rst assertion during MEM_WAIT or ERROR aborts immediately; there is no pending request after reset.

## Configuration
- HAZ_FORWARD_EN defined:
  - fwd_a/fwd_b are active: 10 = EX/MEM (mem_WB[0], mem_rd==ex_rs/rt, ≠0), 01 = MEM/WB (wb_WB[0], wb_rd match), 00 = register file.
  - EX/MEM takes precedence over MEM/WB.
  - Only load-use stalls.
- HAZ_FORWARD_EN undefined:
  - fwd_a=fwd_b=00.
  - The data-hazard stall also fires on a RegWrite match in EX (any ex_WB[0], not just loads) or in MEM (mem_WB[0] & mem_rd match), using the same id_rs/id_rt rule.
  - The register file writes in the first half-cycle, so WB causes no stall.

## Structure
- Package mips_pipe_pkg holds:
  - M/WB bit-index constants (MEM_READ, MEM_WRITE, BRANCH, REG_WRITE, MEM_TO_REG)
  - the FSM state enum
  - FWD_RF/FWD_MEM/FWD_WB encodings
- One combinational sub-module, hazard_fwd_unit, holds the comparators, stall request and forwarding selects. The FSM, counters and priority logic stay in pipe_ctrl_unit.

## Test plan
- lw $2 in EX with ID reading rs=2 → exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
- mem_M=001, dmem_ready low for 3 cycles then high → dmem_req high for 4 cycles, all enables 0 for 3 cycles, RUN afterwards.
- dmem_ready held low for MEM_TIMEOUT cycles → ERROR, mem_err=1, dmem_req=0; rst clears mem_err to 0.
- mem_M=100, mem_zero=1 while ex holds a load-use match → pc_src=1 and three flushes for 1 cycle, no load-use stall.
- With HAZ_FORWARD_EN: mem_rd=5 RegWrite, wb_rd=5 RegWrite, ex_rs=5 → fwd_a=10. ex_rt=0 with mem_rd=0 → fwd_b=00.
- Without HAZ_FORWARD_EN: add $3 in EX, ID reads $3 → pc_en=0 for 2 cycles (EX then MEM match).
